// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a falling-edge byte-addressed data memory.
// One request per handshake: decode, fault-check, one memory access cycle, then a held response.
module load_store_unit #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic [1:0]        RSP_FAULT,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DATA_IN,
    output logic [1:0]        MEM_DATA_SIZE,
    output logic              MEM_SIGNED,
    input  logic [31:0]       MEM_DATA_OUT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_ILLEGAL  = 2'b11
    } fault_t;

    state_t             state_q;
    state_t             state_d;
    fault_t             req_fault;
    fault_t             fault_q;
    logic               illegal;
    logic               out_of_range;
    logic               misaligned;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [31:0]        rdata_q;

    // Request decode, evaluated on the live request inputs in IDLE.
    always_comb begin
        illegal      = 1'b0;
        out_of_range = 1'b0;
        misaligned   = 1'b0;
        req_fault    = FAULT_NONE;

        if (REQ_WRITE) begin
            illegal = REQ_FUNCT3[2] || (REQ_FUNCT3[1:0] == 2'b11);
        end else begin
            illegal = (REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3 == 3'b110) ||
                      (REQ_FUNCT3 == 3'b111);
        end

        out_of_range = (REQ_ADDR >> ADDR_W) != 32'd0;

        misaligned = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                     ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));

        if (illegal) begin
            req_fault = FAULT_ILLEGAL;
        end else if (out_of_range) begin
            req_fault = FAULT_RANGE;
        end else if (misaligned) begin
            req_fault = FAULT_MISALIGN;
        end
    end

    // MEM_WE depends only on state so a store in flight still commits if reset hits mid-access.
    always_comb begin
        state_d   = state_q;
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        MEM_WE    = 1'b0;

        unique case (state_q)
            IDLE: begin
                REQ_READY = RST_N;
                if (REQ_VALID) begin
                    state_d = (req_fault != FAULT_NONE) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                MEM_WE  = wr_q;
                state_d = RESP;
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            rdata_q  <= '0;
            fault_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && REQ_VALID) begin
                wr_q     <= REQ_WRITE;
                addr_q   <= REQ_ADDR[ADDR_W-1:0];
                wdata_q  <= REQ_WDATA;
                size_q   <= REQ_FUNCT3[1:0];
                signed_q <= ~REQ_FUNCT3[2];
                if (req_fault != FAULT_NONE) begin
                    rdata_q <= '0;
                    fault_q <= req_fault;
                end
            end

            if (state_q == ACCESS) begin
                rdata_q <= wr_q ? 32'd0 : MEM_DATA_OUT;
                fault_q <= FAULT_NONE;
            end
        end
    end

    assign MEM_ADDR      = addr_q;
    assign MEM_DATA_IN   = wdata_q;
    assign MEM_DATA_SIZE = size_q;
    assign MEM_SIGNED    = signed_q;
    assign RSP_RDATA     = rdata_q;
    assign RSP_FAULT     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: falling-edge memory model, directed vector table,
// reset corner sequences and randomized traffic against a byte-array reference.
module tb_load_store_unit;

    logic        CLK;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [2:0]  REQ_FUNCT3;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_FAULT;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [31:0] MEM_DATA_IN;
    logic [1:0]  MEM_DATA_SIZE;
    logic        MEM_SIGNED;
    logic [31:0] MEM_DATA_OUT;

    int checks   = 0;
    int failures = 0;
    int we_total = 0;

    logic [7:0] mem     [0:65535] = '{default: 8'h00};
    logic [7:0] ref_mem [0:65535] = '{default: 8'h00};

    load_store_unit #(.ADDR_W(16)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_WRITE    (REQ_WRITE),
        .REQ_FUNCT3   (REQ_FUNCT3),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_WDATA    (REQ_WDATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_READY    (RSP_READY),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_FAULT    (RSP_FAULT),
        .MEM_WE       (MEM_WE),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_DATA_IN  (MEM_DATA_IN),
        .MEM_DATA_SIZE(MEM_DATA_SIZE),
        .MEM_SIGNED   (MEM_SIGNED),
        .MEM_DATA_OUT (MEM_DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: little-endian, acts on the falling edge, read data already extended.
    always @(negedge CLK) begin
        int nb;
        logic [31:0] v;
        nb = (MEM_DATA_SIZE == 2'b00) ? 1 : (MEM_DATA_SIZE == 2'b01) ? 2 : 4;
        if (MEM_WE === 1'b1) begin
            we_total = we_total + 1;
            for (int i = 0; i < nb; i++) mem[16'(MEM_ADDR + 16'(i))] = MEM_DATA_IN[8*i +: 8];
        end
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem[16'(MEM_ADDR + 16'(i))];
        if (MEM_SIGNED && v[8*nb-1]) begin
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        MEM_DATA_OUT <= v;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: architectural effect of one request on a flat byte image.
    task automatic ref_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic [1:0] fault);
        int nb;
        bit legal;
        longint val;
        nb    = 1 << f3[1:0];
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal)                 fault = 2'd3;
        else if (addr > 32'hFFFF)   fault = 2'd2;
        else if (addr % nb != 0)    fault = 2'd1;
        else                        fault = 2'd0;
        rd = '0;
        if (fault == 2'd0) begin
            if (wr) begin
                for (int i = 0; i < nb; i++)
                    ref_mem[int'((addr + 32'(i)) & 32'hFFFF)] = 8'((wdata >> (8*i)) & 32'hFF);
            end else begin
                val = 0;
                for (int i = 0; i < nb; i++)
                    val = val + (longint'(ref_mem[int'((addr + 32'(i)) & 32'hFFFF)]) << (8*i));
                if (!f3[2] && val >= (64'sd1 << (8*nb - 1))) val = val - (64'sd1 << (8*nb));
                rd = val[31:0];
            end
        end
    endtask

    // Present a request and return once it has been accepted (#1 after the accepting edge).
    task automatic issue_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int n;
        REQ_WRITE  = wr;
        REQ_FUNCT3 = f3;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        REQ_VALID  = 1'b1;
        n = 0;
        while (!REQ_READY && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 20) check("req_ready_timeout", 32'(REQ_READY), 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           output logic [31:0] rd, output logic [1:0] fault,
                           output int lat, output int wes);
        int we0;
        logic [31:0] hr;
        logic [1:0]  hf;
        we0 = we_total;
        issue_req(wr, f3, addr, wdata);
        check("mem_addr_latched", 32'(MEM_ADDR), 32'(addr[15:0]));
        check("mem_size_latched", 32'(MEM_DATA_SIZE), 32'(f3[1:0]));
        check("mem_signed_latched", 32'(MEM_SIGNED), 32'(!f3[2]));
        check("mem_wdata_latched", MEM_DATA_IN, wdata);
        // Junk on the request port must be ignored until the response is consumed.
        REQ_WRITE  = 1'($urandom);
        REQ_FUNCT3 = 3'($urandom);
        REQ_ADDR   = $urandom;
        REQ_WDATA  = $urandom;
        lat = 1;
        while (!RSP_VALID && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        hr = RSP_RDATA;
        hf = RSP_FAULT;
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check("hold_valid", 32'(RSP_VALID), 32'd1);
            check("hold_rdata", RSP_RDATA, hr);
            check("hold_fault", 32'(RSP_FAULT), 32'(hf));
            check("hold_req_ready", 32'(REQ_READY), 32'd0);
        end
        rd        = RSP_RDATA;
        fault     = RSP_FAULT;
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        REQ_VALID = 1'b0;
        check("rsp_valid_after_hs", 32'(RSP_VALID), 32'd0);
        check("req_ready_after_hs", 32'(REQ_READY), 32'd1);
        wes = we_total - we0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(REQ_READY), 32'd0);
        check({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
        check({tag, "_rsp_rdata"}, RSP_RDATA, 32'd0);
        check({tag, "_rsp_fault"}, 32'(RSP_FAULT), 32'd0);
        check({tag, "_mem_we"}, 32'(MEM_WE), 32'd0);
        check({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'd0);
        check({tag, "_mem_din"}, MEM_DATA_IN, 32'd0);
        check({tag, "_mem_size"}, 32'(MEM_DATA_SIZE), 32'd0);
        check({tag, "_mem_signed"}, 32'(MEM_SIGNED), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] rd, exp_rd;
        logic [1:0]  fault, exp_fault;
        int          lat, wes, r;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;

        tbl[0] = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0, 2, 1};
        tbl[1] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2'd0, 2, 0};
        tbl[2] = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'hFFFF_FFDE, 2'd0, 2, 0};
        tbl[3] = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h0000_00DE, 2'd0, 2, 0};
        tbl[4] = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'hFFFF_DEAD, 2'd0, 2, 0};
        tbl[5] = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h0000_BEEF, 2'd0, 2, 0};
        tbl[6] = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0000_0000, 2'd1, 1, 0};
        tbl[7] = '{1'b1, 3'b001, 32'h0001_0000, 32'h1234_5678, 32'h0000_0000, 2'd2, 1, 0};
        tbl[8] = '{1'b1, 3'b100, 32'h0000_0100, 32'h1111_1111, 32'h0000_0000, 2'd3, 1, 0};
        tbl[9] = '{1'b0, 3'b011, 32'h0001_0001, 32'h0,        32'h0000_0000, 2'd3, 1, 0};

        RST_N      = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_WRITE  = 1'b0;
        REQ_FUNCT3 = 3'b000;
        REQ_ADDR   = '0;
        REQ_WDATA  = '0;
        RSP_READY  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("ready_after_reset", 32'(REQ_READY), 32'd1);
        check("valid_after_reset", 32'(RSP_VALID), 32'd0);

        for (int i = 0; i < 10; i++) begin
            ref_txn(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, exp_rd, exp_fault);
            run_txn(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, rd, fault, lat, wes);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("vec%0d_fault", i), 32'(fault), 32'(tbl[i].exp_fault));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_we_cycles", i), 32'(wes), 32'(tbl[i].exp_we));
        end

        // Back-pressure: response held for 5 cycles with a competing request pending.
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5, rd, fault, lat, wes);
        check("bp_rdata", rd, 32'hDEAD_BEEF);
        check("bp_fault", 32'(fault), 32'd0);

        // Reset during the ACCESS cycle of a store: the write still lands, the response is dropped.
        issue_req(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D);
        REQ_VALID = 1'b0;
        check("rst_access_we", 32'(MEM_WE), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst_access_we_held", 32'(MEM_WE), 32'd1);
        @(posedge CLK); #1;
        check_reset_outputs("rst_access");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        ref_txn(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, exp_rd, exp_fault);
        @(posedge CLK); #1;
        check("rst_access_no_rsp", 32'(RSP_VALID), 32'd0);
        run_txn(1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, rd, fault, lat, wes);
        check("rst_access_readback", rd, 32'hCAFE_F00D);
        check("rst_access_readback_fault", 32'(fault), 32'd0);

        // Reset while a response is pending drops it.
        issue_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        check("rst_resp_pending", 32'(RSP_VALID), 32'd1);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check("rst_resp_dropped", 32'(RSP_VALID), 32'd0);
        check("rst_resp_rdata", RSP_RDATA, 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int k = 0; k < 200; k++) begin
            wr    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            r     = int'($urandom_range(0, 9));
            if (r == 0)      addr = $urandom | 32'h0001_0000;
            else if (r == 1) addr = 32'h0000_FFF0 + $urandom_range(0, 15);
            else             addr = 32'h0000_0100 + $urandom_range(0, 63);
            ref_txn(wr, f3, addr, wdata, exp_rd, exp_fault);
            run_txn(wr, f3, addr, wdata, int'($urandom_range(0, 3)), rd, fault, lat, wes);
            check("rnd_rdata", rd, exp_rd);
            check("rnd_fault", 32'(fault), 32'(exp_fault));
            check("rnd_latency", 32'(lat), (exp_fault == 2'd0) ? 32'd2 : 32'd1);
            check("rnd_we_cycles", 32'(wes), (wr && exp_fault == 2'd0) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
